mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised byte-serial memory arbiter between N requesting units (instruction fetch, load/store buffer, future prefetcher) and the single 8-bit RAM/IO port. It accepts 1/2/4-byte read or write transactions per channel and arbitrates with fixed-priority or round-robin policy. It serialises bytes onto `mem_a`/`mem_dout`, reassembles little-endian read data, and stalls IO writes on `io_buffer_full`. It supports per-channel flush of in-flight reads on mispredict.

## Interface
- `N_CH`, 2: number of request channels (≥1).
- `ARB_MODE`, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `FLUSH_MASK`, all ones (`{N_CH{1'b1}}`): channel bit set ⇒ that channel's reads abort on `flush`.
- `clk_in`, in, 1: clock, single domain.
- `rst_in`, in, 1: reset, asynchronous, active-high.
- `rdy_in`, in, 1: low ⇒ freeze all state.
- `flush`, in, 1: control hazard / pipeline flush.
- `ch_req`, in, N_CH: request, level; held with fields stable until `ch_done` or abort.
- `ch_wr`, in, N_CH: 1 = write.
- `ch_size`, in, 2·N_CH: 0 = 1 B, 1 = 2 B, 2/3 = 4 B.
- `ch_addr`, in, 32·N_CH: byte address of the lowest byte.
- `ch_wdata`, in, 32·N_CH: write data, byte 0 = bits [7:0].
- `ch_grant`, out, N_CH: one-hot; high while that channel's transaction is active.
- `ch_done`, out, N_CH: one-cycle completion pulse.
- `ch_rdata`, out, 32: read data, zero-extended; valid only with `ch_done`.
- `mem_din`, in, 8: RAM/IO read byte, valid the cycle after its address.
- `mem_dout`, out, 8: write byte.
- `mem_a`, out, 32: memory address.
- `mem_wr`, out, 1: write strobe.
- `io_buffer_full`, in, 1: UART TX buffer full.

## Operation
- States: IDLE, READ, WRITE. Registers: owner index, base addr, byte count n (1/2/4), issue index i, receive index j, wdata, rdata accumulator.
- IDLE: if any eligible `ch_req`, pick winner, latch fields, set `ch_grant`, go READ/WRITE. A channel is ineligible in a cycle where `flush` is high and its `FLUSH_MASK` bit is set.
- Fixed mode: lowest set index wins.
- Round-robin mode: search starts at last winner + 1 (mod N_CH). Pointer resets to N_CH-1, so channel 0 is first.
- READ: while i<n drive `mem_a` = base+i, increment i. Each cycle after an issue, latch `mem_din` into byte j, increment j. When j reaches n, pulse `ch_done[owner]`, drive `ch_rdata`, drop grant, go IDLE.
- WRITE: drive `mem_a` = base+i, `mem_dout` = wdata byte i, `mem_wr` = 1, increment i.
  - If base[17:16]==2'b11 (IO) and `io_buffer_full` is high, hold i and force `mem_wr` = 0.
  - After byte n-1 is written, pulse `ch_done`, go IDLE.
- Address arithmetic: 32-bit, base+i wraps modulo 2^32. No alignment requirement.
- Flush: READ with `FLUSH_MASK[owner]` set ⇒ next state IDLE, no `ch_done`, grant dropped. WRITE is never aborted.
- `rdy_in` low: no register changes; `mem_wr` forced 0; `mem_a` holds.
- Outputs when not issuing: `mem_a` = 0, `mem_wr` = 0, `mem_dout` = 0.
- `ch_req` deasserted while ungranted is legal. Deasserted while granted is illegal; the transaction still completes.

## Timing
- Reset (async): state IDLE; all outputs 0; RR pointer N_CH-1.
- Request seen in IDLE at cycle 0 ⇒ grant registered, visible cycle 1. First byte address on `mem_a` in cycle 1.
- Read of n bytes: addresses cycles 1..n, data sampled cycles 2..n+1, `ch_done` + `ch_rdata` in cycle n+2. Latency: 1 B = 3, 4 B = 6 cycles.
- Write of n bytes, no stall: bytes cycles 1..n, `ch_done` in cycle n+1. Each IO stall cycle adds 1.
- `ch_done` cycle is IDLE and arbitrates, so the next transaction's first byte is in `ch_done` + 1.
- `flush` at cycle t during READ ⇒ IDLE at t+1, `mem_a` = 0 at t+1. A late `mem_din` byte is ignored.
- Simultaneous `flush` and final receive cycle: flush wins, no `ch_done`.

## Test plan
- Reset mid-READ (assert `rst_in` asynchronously at cycle 3) ⇒ all outputs 0 immediately; state IDLE after release.
- Ch0 4-byte read @0x100, memory bytes 11,22,33,44 ⇒ `mem_a` = 0x100..0x103 in cycles 1-4, `ch_done[0]` cycle 6, `ch_rdata` = 0x44332211.
- Ch1 2-byte write 0xBEEF @0x1FFFF ⇒ (0x1FFFF, EF) then (0x20000, BE) with `mem_wr` = 1, `ch_done[1]` cycle 3.
- Both channels request continuously:
  - ARB_MODE = 0 ⇒ ch0 always wins.
  - ARB_MODE = 1 ⇒ grants alternate 0,1,0,1.
- 1-byte write 0x41 @0x30000 with `io_buffer_full` high for 3 cycles ⇒ `mem_wr` low 3 cycles, then 1 cycle high, `ch_done` at cycle 5.
- Ch0 4-byte read, `flush` at cycle 3 ⇒ no `ch_done`, IDLE cycle 4. Repeat as a write ⇒ completes normally, `ch_done` at cycle 5.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial arbiter between N_CH requesters and one 8-bit RAM/IO port.
// Serialises 1/2/4-byte reads and writes, reassembles little-endian read data,
// stalls IO writes while the UART buffer is full, and aborts flushed reads.
module mem_arbiter #(
  parameter int unsigned     N_CH       = 2,
  parameter int unsigned     ARB_MODE   = 0,
  parameter logic [N_CH-1:0] FLUSH_MASK = {N_CH{1'b1}}
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic [N_CH-1:0]      ch_req,
  input  logic [N_CH-1:0]      ch_wr,
  input  logic [2*N_CH-1:0]    ch_size,
  input  logic [32*N_CH-1:0]   ch_addr,
  input  logic [32*N_CH-1:0]   ch_wdata,
  output logic [N_CH-1:0]      ch_grant,
  output logic [N_CH-1:0]      ch_done,
  output logic [31:0]          ch_rdata,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [31:0]          mem_a,
  output logic                 mem_wr,
  input  logic                 io_buffer_full
);

  localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  // Transaction state
  state_e           r_state;
  logic [N_CH-1:0]  r_grant;   // one-hot owner, doubles as the owner index
  logic [N_CH-1:0]  r_done;
  logic [31:0]      r_rdata;
  logic [31:0]      r_base;
  logic [2:0]       r_n;       // byte count: 1, 2 or 4
  logic [2:0]       r_i;       // next byte to issue
  logic [2:0]       r_j;       // next byte to receive
  logic [31:0]      r_wdata;
  logic [31:0]      r_acc;     // read data accumulator
  logic [CW-1:0]    r_rr_ptr;  // last round-robin winner

  // Arbitration results
  logic [N_CH-1:0]  w_elig;
  logic             w_win_valid;
  logic [CW-1:0]    w_win_idx;
  logic [N_CH-1:0]  w_win_oh;
  logic             w_win_wr;
  logic [1:0]       w_win_size;
  logic [2:0]       w_win_n;
  logic [31:0]      w_win_addr;
  logic [31:0]      w_win_wdata;
  int unsigned      w_start;
  int unsigned      w_d;
  int unsigned      w_best_d;

  // Datapath helpers
  logic [31:0]      w_cur_addr;
  logic [7:0]       w_cur_byte;
  logic             w_io_stall;
  logic             w_flush_owner;
  logic [31:0]      w_acc_next;

  // Flushable channels sit out arbitration in a flush cycle.
  assign w_elig = ch_req & ~(flush ? FLUSH_MASK : '0);

  // Pick the winner: smallest distance from the search start among eligible channels.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_win_oh    = '0;
    w_win_wr    = 1'b0;
    w_win_size  = '0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    w_d         = 0;
    w_best_d    = N_CH;
    w_start     = (ARB_MODE == 1) ? ((32'(r_rr_ptr) + 32'd1) % N_CH) : 32'd0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_d = (c + N_CH - w_start) % N_CH;
      if (w_elig[c] && (w_d < w_best_d)) begin
        w_best_d    = w_d;
        w_win_valid = 1'b1;
        w_win_idx   = CW'(c);
        w_win_oh    = '0;
        w_win_oh[c] = 1'b1;
        w_win_wr    = ch_wr[c];
        w_win_size  = ch_size[c*2 +: 2];
        w_win_addr  = ch_addr[c*32 +: 32];
        w_win_wdata = ch_wdata[c*32 +: 32];
      end
    end
  end

  // Sizes 2 and 3 both mean a 4-byte transfer.
  assign w_win_n = (w_win_size == 2'd0) ? 3'd1 :
                   (w_win_size == 2'd1) ? 3'd2 : 3'd4;

  // Address wraps naturally at 2^32; IO decode uses the base address only.
  assign w_cur_addr    = r_base + {29'b0, r_i};
  assign w_cur_byte    = r_wdata[{r_i[1:0], 3'b000} +: 8];
  assign w_io_stall    = (r_base[17:16] == 2'b11) && io_buffer_full;
  assign w_flush_owner = flush && |(FLUSH_MASK & r_grant);

  // Merge the byte arriving this cycle into the accumulator.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{r_j[1:0], 3'b000} +: 8] = mem_din;
  end

  // Main FSM: arbitration, byte issue/receive, completion and flush abort.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= StIdle;
      r_grant  <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_base   <= '0;
      r_n      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_wdata  <= '0;
      r_acc    <= '0;
      r_rr_ptr <= CW'(N_CH - 1);
    end else if (rdy_in) begin
      r_done  <= '0;
      r_rdata <= '0;
      unique case (r_state)
        StIdle: begin
          if (w_win_valid) begin
            r_grant  <= w_win_oh;
            r_base   <= w_win_addr;
            r_n      <= w_win_n;
            r_i      <= '0;
            r_j      <= '0;
            r_wdata  <= w_win_wdata;
            r_acc    <= '0;
            r_rr_ptr <= w_win_idx;
            r_state  <= w_win_wr ? StWrite : StRead;
          end
        end
        StRead: begin
          if (w_flush_owner) begin
            // Abort wins over a coincident final receive; late bytes are dropped.
            r_grant <= '0;
            r_state <= StIdle;
          end else begin
            if (r_i < r_n) begin
              r_i <= r_i + 3'd1;
            end
            if (r_j < r_i) begin
              r_acc <= w_acc_next;
              r_j   <= r_j + 3'd1;
              if (r_j + 3'd1 == r_n) begin
                r_done  <= r_grant;
                r_rdata <= w_acc_next;
                r_grant <= '0;
                r_state <= StIdle;
              end
            end
          end
        end
        StWrite: begin
          if (!w_io_stall) begin
            r_i <= r_i + 3'd1;
            if (r_i + 3'd1 == r_n) begin
              r_done  <= r_grant;
              r_grant <= '0;
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Memory port: idle values are zero; strobe is suppressed by stall or freeze.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    unique case (r_state)
      StRead: begin
        if (r_i < r_n) begin
          mem_a = w_cur_addr;
        end
      end
      StWrite: begin
        mem_a    = w_cur_addr;
        mem_dout = w_cur_byte;
        mem_wr   = rdy_in && !w_io_stall;
      end
      default: ;
    endcase
  end

  assign ch_grant = r_grant;
  assign ch_done  = r_done;
  assign ch_rdata = r_rdata;

  // At most one owner and one completion at a time.
  assert property (@(posedge clk_in) disable iff (rst_in) $onehot0(r_grant));
  assert property (@(posedge clk_in) disable iff (rst_in) $onehot0(r_done));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a fixed-priority and a round-robin instance share stimulus.
// Each task pushes the expected per-cycle port trace, then pops and compares it.
module tb_mem_arbiter;

  typedef struct packed {
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [1:0]  ch_req;
  logic [1:0]  ch_wr;
  logic [3:0]  ch_size;
  logic [63:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [7:0]  mem_din = 8'h00;
  logic        io_full;

  logic [1:0]  f_grant, f_done, r_grant, r_done;
  logic [31:0] f_rdata, f_a, r_rdata, r_a;
  logic [7:0]  f_dout, r_dout;
  logic        f_wr, r_wr;

  logic [7:0]  ram [0:255];
  obs_t        exp_q[$];
  obs_t        exp_rr_q[$];
  obs_t        got, want;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.N_CH(2), .ARB_MODE(0)) u_fix (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush(flush),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_grant(f_grant), .ch_done(f_done), .ch_rdata(f_rdata),
    .mem_din(mem_din), .mem_dout(f_dout), .mem_a(f_a), .mem_wr(f_wr),
    .io_buffer_full(io_full)
  );

  mem_arbiter #(.N_CH(2), .ARB_MODE(1)) u_rr (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush(flush),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_grant(r_grant), .ch_done(r_done), .ch_rdata(r_rdata),
    .mem_din(mem_din), .mem_dout(r_dout), .mem_a(r_a), .mem_wr(r_wr),
    .io_buffer_full(io_full)
  );

  // Synchronous RAM model: data for an address appears the following cycle.
  always @(posedge clk) mem_din <= ram[f_a[7:0]];

  function automatic obs_t mk(input logic [1:0] g, input logic [1:0] d, input logic [31:0] rd,
                              input logic [31:0] a, input logic w, input logic [7:0] o);
    obs_t t;
    t.grant = g; t.done = d; t.rdata = rd; t.a = a; t.wr = w; t.dout = o;
    return t;
  endfunction

  function automatic obs_t obs_fix();
    return mk(f_grant, f_done, f_rdata, f_a, f_wr, f_dout);
  endfunction

  function automatic obs_t obs_rr();
    return mk(r_grant, r_done, r_rdata, r_a, r_wr, r_dout);
  endfunction

  task automatic set_ch(input int c, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd);
    ch_wr[c]            = wr;
    ch_size[c*2 +: 2]   = sz;
    ch_addr[c*32 +: 32] = addr;
    ch_wdata[c*32 +: 32] = wd;
  endtask

  task automatic test_reset();
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    @(negedge clk);
    got = obs_fix(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_fix got=%h expected=%h", got, want);
    end
    got = obs_rr(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_rr got=%h expected=%h", got, want);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    got = obs_fix(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_release got=%h expected=%h", got, want);
    end
    @(posedge clk); #1;
  endtask

  // Both channels request 1-byte writes continuously for four grants.
  task automatic test_arbitration();
    set_ch(0, 1'b1, 2'd0, 32'h10, 32'h5A);
    set_ch(1, 1'b1, 2'd0, 32'h20, 32'hA5);
    ch_req = 2'b11;
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_rr_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int g = 0; g < 4; g++) begin
      exp_q.push_back(mk(2'b01, 2'b00, 32'h0, 32'h10, 1'b1, 8'h5A));
      exp_q.push_back(mk(2'b00, 2'b01, 32'h0, 32'h0, 1'b0, 8'h00));
      if (g % 2 == 0) begin
        exp_rr_q.push_back(mk(2'b01, 2'b00, 32'h0, 32'h10, 1'b1, 8'h5A));
        exp_rr_q.push_back(mk(2'b00, 2'b01, 32'h0, 32'h0, 1'b0, 8'h00));
      end else begin
        exp_rr_q.push_back(mk(2'b10, 2'b00, 32'h0, 32'h20, 1'b1, 8'hA5));
        exp_rr_q.push_back(mk(2'b00, 2'b10, 32'h0, 32'h0, 1'b0, 8'h00));
      end
    end
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_rr_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int c = 0; c < 10; c++) begin
      if (c == 8) ch_req = 2'b00;
      @(negedge clk);
      got = obs_fix(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL arb_fixed cycle %0d got=%h expected=%h", c, got, want);
      end
      got = obs_rr(); want = exp_rr_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL arb_rr cycle %0d got=%h expected=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_read4();
    set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
    ch_req = 2'b01;
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(2'b01, 2'b00, 32'h0, 32'h100 + k, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b01, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b00, 2'b01, 32'h44332211, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int c = 0; c < 8; c++) begin
      if (c == 6) ch_req = 2'b00;
      @(negedge clk);
      got = obs_fix(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL read4 cycle %0d got=%h expected=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_wrap();
    set_ch(1, 1'b1, 2'd1, 32'h1FFFF, 32'h0000BEEF);
    ch_req = 2'b10;
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b10, 2'b00, 32'h0, 32'h1FFFF, 1'b1, 8'hEF));
    exp_q.push_back(mk(2'b10, 2'b00, 32'h0, 32'h20000, 1'b1, 8'hBE));
    exp_q.push_back(mk(2'b00, 2'b10, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int c = 0; c < 5; c++) begin
      if (c == 3) ch_req = 2'b00;
      @(negedge clk);
      got = obs_fix(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL write2 cycle %0d got=%h expected=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_io_stall();
    set_ch(0, 1'b1, 2'd0, 32'h30000, 32'h41);
    ch_req = 2'b01;
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(2'b01, 2'b00, 32'h0, 32'h30000, 1'b0, 8'h41));
    exp_q.push_back(mk(2'b01, 2'b00, 32'h0, 32'h30000, 1'b1, 8'h41));
    exp_q.push_back(mk(2'b00, 2'b01, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int c = 0; c < 7; c++) begin
      if (c == 1) io_full = 1'b1;
      if (c == 4) io_full = 1'b0;
      if (c == 5) ch_req = 2'b00;
      @(negedge clk);
      got = obs_fix(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL io_stall cycle %0d got=%h expected=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_read();
    set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
    ch_req = 2'b01;
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(2'b01, 2'b00, 32'h0, 32'h100 + k, 1'b0, 8'h00));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int c = 0; c < 8; c++) begin
      if (c == 3) flush = 1'b1;
      if (c == 4) begin flush = 1'b0; ch_req = 2'b00; end
      @(negedge clk);
      got = obs_fix(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL flush_read cycle %0d got=%h expected=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_write();
    logic [31:0] wd;
    wd = 32'hA1B2C3D4;
    set_ch(0, 1'b1, 2'd3, 32'h200, wd);
    ch_req = 2'b01;
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(2'b01, 2'b00, 32'h0, 32'h200 + k, 1'b1, wd[k*8 +: 8]));
    exp_q.push_back(mk(2'b00, 2'b01, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int c = 0; c < 7; c++) begin
      if (c == 3) flush = 1'b1;
      if (c == 4) flush = 1'b0;
      if (c == 5) ch_req = 2'b00;
      @(negedge clk);
      got = obs_fix(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL flush_write cycle %0d got=%h expected=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rdy_freeze();
    set_ch(1, 1'b1, 2'd0, 32'h40, 32'h77);
    ch_req = 2'b10;
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b10, 2'b00, 32'h0, 32'h40, 1'b0, 8'h77));
    exp_q.push_back(mk(2'b10, 2'b00, 32'h0, 32'h40, 1'b1, 8'h77));
    exp_q.push_back(mk(2'b00, 2'b10, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    for (int c = 0; c < 5; c++) begin
      if (c == 1) rdy = 1'b0;
      if (c == 2) rdy = 1'b1;
      if (c == 3) ch_req = 2'b00;
      @(negedge clk);
      got = obs_fix(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL rdy_freeze cycle %0d got=%h expected=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_read();
    set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
    ch_req = 2'b01;
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b01, 2'b00, 32'h0, 32'h100, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b01, 2'b00, 32'h0, 32'h101, 1'b0, 8'h00));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      got = obs_fix(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL rst_mid pre cycle %0d got=%h expected=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    exp_q.push_back(mk(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 8'h00));
    #2 rst = 1'b1;
    #1;
    got = obs_fix(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL rst_mid async got=%h expected=%h", got, want);
    end
    @(posedge clk); #1;
    ch_req = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    got = obs_fix(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL rst_mid idle got=%h expected=%h", got, want);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ram[k] = 8'(k) ^ 8'h5A;
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_arbitration();
    test_read4();
    test_write_wrap();
    test_io_stall();
    test_flush_read();
    test_flush_write();
    test_rdy_freeze();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
